// File: rtl/regfile_sb.sv
// Multi-ported integer register file with per-register scoreboard (busy) bits.
// Writes forward combinationally to reads; r0 is hardwired zero; r2/r3 reset to SP/HP.
module regfile_sb #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      ADDR_W  = 6,
  parameter int unsigned      NRD     = 2,
  parameter int unsigned      NWR     = 2,
  parameter logic [WIDTH-1:0] R2_INIT = WIDTH'(32'h0004_0000),
  parameter logic [WIDTH-1:0] R3_INIT = WIDTH'(32'h0001_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*WIDTH-1:0]  wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*WIDTH-1:0]  rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_rdy,
  input  logic                  flush
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs   [NREG];
  logic [NREG-1:0]   busy;

  logic [ADDR_W-1:0] wr_addr [NWR];
  logic [WIDTH-1:0]  wr_dat  [NWR];
  logic [ADDR_W-1:0] rd_addr [NRD];

  logic [NREG-1:0]   wr_hit;
  logic [WIDTH-1:0]  wr_val  [NREG];
  logic              rsv_take;

  always_comb begin
    for (int unsigned k = 0; k < NWR; k++) begin
      wr_addr[k] = waddr[k*ADDR_W +: ADDR_W];
      wr_dat[k]  = wdata[k*WIDTH +: WIDTH];
    end
    for (int unsigned j = 0; j < NRD; j++) begin
      rd_addr[j] = raddr[j*ADDR_W +: ADDR_W];
    end
  end

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index port wins. Gated by rst so nothing forwards during reset.
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      wr_val[r] = '0;
    end
    for (int unsigned k = 0; k < NWR; k++) begin
      if (!rst && we[k] && (wr_addr[k] != '0)) begin
        wr_hit[wr_addr[k]] = 1'b1;
        wr_val[wr_addr[k]] = wr_dat[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if (rd_addr[j] != '0) begin
        rdata[j*WIDTH +: WIDTH] = wr_hit[rd_addr[j]] ? wr_val[rd_addr[j]]
                                                      : regs[rd_addr[j]];
        rbusy[j] = busy[rd_addr[j]] & ~wr_hit[rd_addr[j]];
      end
    end
  end

  always_comb begin
    rsv_rdy  = !(busy[rsv_addr] && !wr_hit[rsv_addr]);
    rsv_take = !rst && rsv_en && rsv_rdy && (rsv_addr != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r == 2)      regs[r] <= R2_INIT;
        else if (r == 3) regs[r] <= R3_INIT;
        else             regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
    end
  end

  // Writeback clears a reservation, a same-cycle reservation re-sets it,
  // and flush overrides both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
        busy[r] <= (busy[r] & ~wr_hit[r]) |
                   (rsv_take & (rsv_addr == ADDR_W'(r)));
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters.
module tb_regfile_sb;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NRD    = 2;
  localparam int unsigned NWR    = 2;
  localparam logic [31:0] R2_RST = 32'h0004_0000;
  localparam logic [31:0] R3_RST = 32'h0001_0000;

  logic                  clk;
  logic                  rst;
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*WIDTH-1:0]  wdata;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*WIDTH-1:0]  rdata;
  logic [NRD-1:0]        rbusy;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  rsv_rdy;
  logic                  flush;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR),
    .R2_INIT(R2_RST),
    .R3_INIT(R3_RST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rsv_rdy (rsv_rdy),
    .flush   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    raddr = '0;
    idle();

    // Asynchronous reset between edges, with a write attempted meanwhile
    #2 rst = 1'b1;
    we = 2'b01; waddr = {6'd0, 6'd2}; wdata = {32'h0, 32'hDEAD_BEEF};
    raddr = {6'd3, 6'd2};
    #1;
    check("rst_r2", rdata[31:0], R2_RST);
    check("rst_r3", rdata[63:32], R3_RST);
    check("rst_rbusy", {30'd0, rbusy}, 32'd0);
    check("rst_rsv_rdy", {31'd0, rsv_rdy}, 32'd1);
    tick();
    check("rst_wr_ignored", rdata[31:0], R2_RST);
    raddr = {6'd63, 6'd5};
    #1;
    check("rst_other", rdata[31:0] | rdata[63:32], 32'd0);
    rst = 1'b0;
    idle();
    tick();
    raddr = {6'd3, 6'd2};
    #1;
    check("post_rst_r2", rdata[31:0], R2_RST);

    // Two ports hit the same register: port 1 wins, forwarded same cycle
    we = 2'b11; waddr = {6'd5, 6'd5}; wdata = {32'h0000_BBBB, 32'h0000_AAAA};
    raddr = {6'd0, 6'd5};
    #1;
    check("fwd_collide", rdata[31:0], 32'h0000_BBBB);
    tick();
    idle();
    #1;
    check("stored_collide", rdata[31:0], 32'h0000_BBBB);

    // Independent writes on both ports
    we = 2'b11; waddr = {6'd11, 6'd10}; wdata = {32'h2222_0000, 32'h0000_1111};
    tick();
    idle();
    raddr = {6'd11, 6'd10};
    #1;
    check("wr_p0", rdata[31:0], 32'h0000_1111);
    check("wr_p1", rdata[63:32], 32'h2222_0000);

    // Reserve r7, then writeback clears it
    rsv_en = 1'b1; rsv_addr = 6'd7;
    tick();
    rsv_en = 1'b0; raddr = {6'd0, 6'd7};
    #1;
    check("r7_rdy_busy", {31'd0, rsv_rdy}, 32'd0);
    check("r7_rbusy", {31'd0, rbusy[0]}, 32'd1);
    we = 2'b01; waddr = {6'd0, 6'd7}; wdata = {32'h0, 32'h0000_1234};
    #1;
    check("r7_wb_rbusy", {31'd0, rbusy[0]}, 32'd0);
    check("r7_wb_rdy", {31'd0, rsv_rdy}, 32'd1);
    check("r7_wb_fwd", rdata[31:0], 32'h0000_1234);
    tick();
    idle();
    rsv_addr = 6'd7;
    #1;
    check("r7_after_rbusy", {31'd0, rbusy[0]}, 32'd0);
    check("r7_after_rdy", {31'd0, rsv_rdy}, 32'd1);
    check("r7_after_data", rdata[31:0], 32'h0000_1234);

    // r0 ignores writes and reservations
    we = 2'b01; waddr = '0; wdata = {32'h0, 32'h0000_FFFF};
    rsv_en = 1'b1; rsv_addr = 6'd0; raddr = '0;
    #1;
    check("r0_fwd", rdata[31:0], 32'd0);
    check("r0_rdy", {31'd0, rsv_rdy}, 32'd1);
    tick();
    idle();
    #1;
    check("r0_data", rdata[31:0], 32'd0);
    check("r0_rbusy", {31'd0, rbusy[0]}, 32'd0);

    // Reserve r4, r9; flush overrides a concurrent reservation of r12
    rsv_en = 1'b1; rsv_addr = 6'd4;
    tick();
    rsv_addr = 6'd9;
    tick();
    rsv_en = 1'b0;
    raddr = {6'd9, 6'd4};
    #1;
    check("pre_flush_busy", {30'd0, rbusy}, 32'd3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 6'd12;
    tick();
    idle();
    #1;
    check("flush_r4_r9", {30'd0, rbusy}, 32'd0);
    raddr = {6'd12, 6'd12};
    #1;
    check("flush_r12", {30'd0, rbusy}, 32'd0);

    // Write and reserve r6 together: data written, busy set
    we = 2'b01; waddr = {6'd0, 6'd6}; wdata = {32'h0, 32'h0000_0055};
    rsv_en = 1'b1; rsv_addr = 6'd6;
    tick();
    idle();
    raddr = {6'd0, 6'd6};
    #1;
    check("r6_data", rdata[31:0], 32'h0000_0055);
    check("r6_busy", {31'd0, rbusy[0]}, 32'd1);

    // Port 1 writeback clears busy too; reservation with rsv_rdy=0 ignored
    rsv_en = 1'b1; rsv_addr = 6'd6;
    tick();
    idle();
    we = 2'b10; waddr = {6'd6, 6'd0}; wdata = {32'h0000_0077, 32'h0};
    tick();
    idle();
    #1;
    check("r6_p1_clear", {31'd0, rbusy[0]}, 32'd0);
    check("r6_p1_data", rdata[31:0], 32'h0000_0077);

    // Reset mid-operation drops reservations and data
    rsv_en = 1'b1; rsv_addr = 6'd20;
    tick();
    idle();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    raddr = {6'd5, 6'd20};
    #1;
    check("rst2_r20_busy", {30'd0, rbusy}, 32'd0);
    check("rst2_r5_data", rdata[63:32], 32'd0);
    rsv_en = 1'b1; rsv_addr = 6'd21;
    tick();
    idle();
    raddr = {6'd0, 6'd21};
    #1;
    check("rst2_first_edge", {31'd0, rbusy[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
